// File: rtl/vx_wb_sequencer.sv
// vx_wb_sequencer: turns commit packets into per-register writeback beats; mload packets become four beats rd..rd+3.
// Define WB_SEQ_PERF_EN to add the perf_wb_beats / perf_mloads counters.
`ifndef UUID_WIDTH
`define UUID_WIDTH 16
`endif
`ifndef ISSUE_WIS_BITS
`define ISSUE_WIS_BITS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 16
`endif

module vx_wb_sequencer #(
  parameter int CORE_ID  = 0,
  parameter int ISSUE_ID = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             commit_valid,
  output logic                             commit_ready,
  input  logic [`UUID_WIDTH-1:0]           commit_uuid,
  input  logic [`ISSUE_WIS_BITS-1:0]       commit_wis,
  input  logic [`NUM_THREADS-1:0]          commit_tmask,
  input  logic [`XLEN-1:0]                 commit_PC,
  input  logic [`NR_BITS-1:0]              commit_rd,
  input  logic                             commit_wb,
  input  logic                             commit_mload,
  input  logic [4*`NUM_THREADS*`XLEN-1:0]  commit_data,
  output logic                             wb_valid,
  output logic [`UUID_WIDTH-1:0]           wb_uuid,
  output logic [`ISSUE_WIS_BITS-1:0]       wb_wis,
  output logic [`NUM_THREADS-1:0]          wb_tmask,
  output logic [`XLEN-1:0]                 wb_PC,
  output logic [`NR_BITS-1:0]              wb_rd,
  output logic [`NUM_THREADS*`XLEN-1:0]    wb_data,
  output logic                             wb_sop,
  output logic                             wb_eop
`ifdef WB_SEQ_PERF_EN
  ,
  output logic [`PERF_CTR_BITS-1:0]        perf_wb_beats,
  output logic [`PERF_CTR_BITS-1:0]        perf_mloads
`endif
);
  localparam int DW  = `NUM_THREADS*`XLEN;
  localparam int NRB = `NR_BITS;
  typedef enum logic {IDLE, BURST} state_e;
  state_e                        state_q;
  logic [1:0]                    idx_q;
  logic [NRB-1:0]                rd_q;
  logic [3*DW-1:0]               data_q;
  logic                          wb_valid_q;
  logic [`UUID_WIDTH-1:0]        wb_uuid_q;
  logic [`ISSUE_WIS_BITS-1:0]    wb_wis_q;
  logic [`NUM_THREADS-1:0]       wb_tmask_q;
  logic [`XLEN-1:0]              wb_PC_q;
  logic [NRB-1:0]                wb_rd_q;
  logic [DW-1:0]                 wb_data_q;
  logic                          accept, launch;
  assign commit_ready = (state_q == IDLE) && !reset;
  assign accept       = commit_valid && commit_ready;
  assign launch       = (accept && commit_wb) || (state_q == BURST);
  assign wb_valid     = wb_valid_q;
  assign wb_uuid      = wb_uuid_q;
  assign wb_wis       = wb_wis_q;
  assign wb_tmask     = wb_tmask_q;
  assign wb_PC        = wb_PC_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_sop       = wb_valid_q;
  assign wb_eop       = wb_valid_q;
  // data_q keeps only slots 1..3; slot 0 goes straight to the output on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_uuid_q  <= '0;
      wb_wis_q   <= '0;
      wb_tmask_q <= '0;
      wb_PC_q    <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= launch;
      if (accept && commit_wb) begin
        wb_uuid_q  <= commit_uuid;
        wb_wis_q   <= commit_wis;
        wb_tmask_q <= commit_tmask;
        wb_PC_q    <= commit_PC;
        wb_rd_q    <= commit_rd;
        wb_data_q  <= commit_data[DW-1:0];
        rd_q       <= commit_rd;
        data_q     <= commit_data[4*DW-1:DW];
        state_q    <= commit_mload ? BURST : IDLE;
        idx_q      <= commit_mload ? 2'd1 : 2'd0;
      end else if (state_q == BURST) begin
        wb_rd_q   <= rd_q + NRB'(idx_q);
        wb_data_q <= data_q[(int'(idx_q)-1)*DW +: DW];
        idx_q     <= idx_q + 2'd1;
        state_q   <= (idx_q == 2'd3) ? IDLE : BURST;
      end
    end
  end
`ifdef WB_SEQ_PERF_EN
  localparam int PCB = `PERF_CTR_BITS;
  logic [PCB-1:0] perf_beats_q, perf_mloads_q;
  assign perf_wb_beats = perf_beats_q;
  assign perf_mloads   = perf_mloads_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_beats_q  <= '0;
      perf_mloads_q <= '0;
    end else begin
      perf_beats_q  <= perf_beats_q + PCB'(launch);
      perf_mloads_q <= perf_mloads_q + PCB'(accept && commit_mload);
    end
  end
`endif
  assert property (@(posedge clk) disable iff (reset)
    (commit_valid && !commit_ready) |=> (commit_valid && $stable({commit_uuid, commit_wis, commit_tmask,
      commit_PC, commit_rd, commit_wb, commit_mload, commit_data})))
    else $error("core%0d issue%0d: commit packet dropped or changed while stalled", CORE_ID, ISSUE_ID);
endmodule

// File: doc/vx_wb_sequencer.md
VX_WB_SEQUENCER -- requirements
Module: VX_wb_sequencer

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core index used only in simulation trace text.
REQ-002 SHALL have parameter ISSUE_ID, default 0, issue slot index used only in simulation trace text.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port commit_valid, input, 1, a result packet is offered.
REQ-006 SHALL have port commit_ready, output, 1, the packet is accepted this cycle when high together with commit_valid.
REQ-007 SHALL have the following input packet fields:
- commit_uuid, `UUID_WIDTH.
- commit_wis, ISSUE_WIS_W.
- commit_tmask, `NUM_THREADS.
- commit_PC, `XLEN.
- commit_rd, `NR_BITS.
- commit_wb, 1: write the register file.
- commit_mload, 1: multi-register load writing rd..rd+3.
REQ-008 SHALL have port commit_data, input, 4 x `NUM_THREADS x `XLEN; slot k is the data for register rd+k, and only slot 0 is used when commit_mload=0.
REQ-009 SHALL have port wb_valid, output, 1, a writeback beat is present; there is no backpressure.
REQ-010 SHALL have output ports wb_uuid, wb_wis, wb_tmask, wb_PC, wb_rd and wb_data, with widths as the commit fields and wb_data `NUM_THREADS x `XLEN.
REQ-011 SHALL have output ports wb_sop and wb_eop, each 1 bit, marking the start and end of a per-register writeback.

Function
REQ-012 SHALL implement a two-state FSM:
- IDLE: nothing pending beyond the current output.
- BURST: beat index idx in {1,2,3} pending.
REQ-013 SHALL drive commit_ready=1 exactly when the state is IDLE.
REQ-014 SHALL, in IDLE on accept with commit_wb=1, register the packet and drive beat 0 (wb_rd=commit_rd, wb_data=slot 0) on the next cycle.
REQ-015 SHALL, in IDLE on accept with commit_wb=0, consume the packet and emit no beat.
REQ-016 SHALL, on accept with commit_wb=1 and commit_mload=1, enter BURST with idx=1 while beat 0 is output.
REQ-017 SHALL, in BURST, output beat idx each cycle with wb_rd=rd+idx and wb_data=slot idx, then increment idx.
REQ-018 SHALL return to IDLE in the cycle beat 3 is driven.
REQ-019 SHALL compute rd+idx modulo 2^`NR_BITS (wrap-around), matching the issue-side in-use marking.
REQ-020 SHALL drive wb_sop=1 and wb_eop=1 on every beat, so each register is released individually.
REQ-021 SHALL hold uuid, wis, tmask and PC constant across all beats of a packet.
REQ-022 SHALL have a latency of 1 cycle from accept to beat 0.
REQ-023 SHALL sustain a throughput of 1 single-register packet per cycle and 1 mload per 4 cycles (packet accepted at T gives beats T+1..T+4; next accept is possible at T+4).
REQ-024 SHALL drive wb_valid=0 in any cycle with no beat; wb_* data are don't-care when wb_valid=0.
REQ-025 SHALL, in simulation, assert that commit_valid is never dropped, or its fields changed, while commit_ready=0.

Reset
REQ-026 SHALL set state=IDLE, idx=0 and wb_valid=0 one cycle after reset is sampled high; all other wb_* outputs reset to 0.
REQ-027 SHALL abandon any in-flight burst on reset mid-operation, with no further beats emitted.
REQ-028 SHALL drive commit_ready=0 while reset is high.

Configuration
REQ-029 SHALL, with WB_SEQ_PERF_EN defined, add outputs perf_wb_beats and perf_mloads (`PERF_CTR_BITS each), counting beats emitted and mload packets accepted; both reset to 0 and wrap on overflow.
REQ-030 SHALL, without WB_SEQ_PERF_EN, omit these ports and counters, with identical functional behaviour.

Verification
REQ-031 SHALL cover: single accept at T with rd=5, wb=1, mload=0 -> at T+1 wb_valid=1, wb_rd=5, sop=eop=1; at T+2 wb_valid=0.
REQ-032 SHALL cover: mload with rd=8 accepted at T -> wb_rd=8,9,10,11 at T+1..T+4, data slots 0..3, commit_ready=0 at T+1..T+3 and 1 at T+4.
REQ-033 SHALL cover: mload with rd=30 and `NR_BITS=5 -> wb_rd=30,31,0,1.
REQ-034 SHALL cover: back-to-back single packets rd=1,2,3 at T,T+1,T+2 -> wb_rd=1,2,3 at T+1..T+3 with no bubbles.
REQ-035 SHALL cover: commit_wb=0 packet -> accepted, no wb_valid pulse.
REQ-036 SHALL cover: reset asserted at T+2 of an mload -> wb_valid=0 from T+3 onward, commit_ready=1 after reset deasserts, and, with WB_SEQ_PERF_EN, both counters=0.
